// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle sequencer and the RV32I datapath/memory.
// The slave modport is the sequencer side; the master modport is the datapath side.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             branch_taken;
    logic [1:0]       ALUOp;
    logic [1:0]       RegSrc;
    logic             ALUSrc;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             Branch;
    logic             IFetch;
    logic             IRWrite;
    logic             PCWrite;
    logic [1:0]       PCSel;
    logic             trap;
    logic [1:0]       cause;
    logic [CNT_W-1:0] instret;

    modport master (
        output opcode, mem_ready, branch_taken,
        input  ALUOp, RegSrc, ALUSrc, RegWrite, MemRead, MemWrite, Branch,
        input  IFetch, IRWrite, PCWrite, PCSel, trap, cause, instret
    );

    modport slave (
        input  opcode, mem_ready, branch_taken,
        output ALUOp, RegSrc, ALUSrc, RegWrite, MemRead, MemWrite, Branch,
        output IFetch, IRWrite, PCWrite, PCSel, trap, cause, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-handshake stalls,
// illegal-opcode and bus-timeout traps. Optional retired-instruction counter is built
// only when CTRL_INSTRET_EN is defined; otherwise instret reads 0.
module multicycle_control #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WAIT_LIMIT = 0
) (
    input logic                 clk,
    input logic                 rst,
    multicycle_control_if.slave io_ctrl
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;

    typedef enum logic [3:0] {
        OpcR, OpcI, OpcLd, OpcSt, OpcBr, OpcLui, OpcAuipc, OpcJal, OpcJalr, OpcFence,
        OpcIllegal
    } opc_e;

    function automatic opc_e f_decode(input logic [6:0] op);
        case (op)
            7'b0110011: return OpcR;
            7'b0010011: return OpcI;
            7'b0000011: return OpcLd;
            7'b0100011: return OpcSt;
            7'b1100011: return OpcBr;
            7'b0110111: return OpcLui;
            7'b0010111: return OpcAuipc;
            7'b1101111: return OpcJal;
            7'b1100111: return OpcJalr;
            7'b0001111: return OpcFence;
            default:    return OpcIllegal;
        endcase
    endfunction

    state_e      r_state;
    state_e      w_state_next;
    logic [6:0]  r_op;
    logic [31:0] r_wait;
    logic [1:0]  r_cause;
    logic [1:0]  w_cause_next;
    opc_e        w_opc_live;
    opc_e        w_opc_q;
    logic        w_mem_state;
    logic        w_timeout;
    logic        w_ready;

    logic [1:0]  w_alu_op;
    logic [1:0]  w_reg_src;
    logic        w_alu_src;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_branch;
    logic        w_ifetch;
    logic        w_ir_write;
    logic        w_pc_write;
    logic [1:0]  w_pc_sel;

    // DECODE sees the live opcode; later states use the copy latched at the end of DECODE.
    assign w_opc_live  = f_decode(io_ctrl.opcode);
    assign w_opc_q     = f_decode(r_op);
    assign w_mem_state = (r_state == StFetch) || (r_state == StMem);
    // Timeout wins only once the counter already sits at the limit.
    assign w_timeout   = (WAIT_LIMIT != 0) && w_mem_state && (r_wait == WAIT_LIMIT);
    assign w_ready     = io_ctrl.mem_ready && !w_timeout;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Opcode latch, trap cause and access wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= 7'd0;
            r_cause <= 2'd0;
            r_wait  <= 32'd0;
        end else begin
            if (r_state == StDecode) begin
                r_op <= io_ctrl.opcode;
            end
            r_cause <= w_cause_next;
            // Any state change clears it, so every entry to FETCH/MEM starts from zero.
            if (w_state_next != r_state) begin
                r_wait <= 32'd0;
            end else if (w_mem_state && !io_ctrl.mem_ready && (r_wait != 32'hffff_ffff)) begin
                r_wait <= r_wait + 32'd1;
            end
        end
    end

    // Next-state and trap-cause selection.
    always_comb begin
        w_state_next = r_state;
        w_cause_next = r_cause;
        case (r_state)
            StFetch: begin
                if (w_timeout) begin
                    w_state_next = StTrap;
                    w_cause_next = 2'd2;
                end else if (io_ctrl.mem_ready) begin
                    w_state_next = StDecode;
                end
            end
            StDecode: begin
                case (w_opc_live)
                    OpcIllegal: begin
                        w_state_next = StTrap;
                        w_cause_next = 2'd1;
                    end
                    OpcFence: w_state_next = StFetch;
                    default:  w_state_next = StExec;
                endcase
            end
            StExec: begin
                case (w_opc_q)
                    OpcBr:        w_state_next = StFetch;
                    OpcLd, OpcSt: w_state_next = StMem;
                    default:      w_state_next = StWb;
                endcase
            end
            StMem: begin
                if (w_timeout) begin
                    w_state_next = StTrap;
                    w_cause_next = 2'd2;
                end else if (io_ctrl.mem_ready) begin
                    w_state_next = (w_opc_q == OpcSt) ? StFetch : StWb;
                end
            end
            StWb:    w_state_next = StFetch;
            StTrap:  w_state_next = StTrap;
            default: w_state_next = StFetch;
        endcase
    end

    // Datapath control decode from state and opcode.
    always_comb begin
        w_alu_op    = 2'd0;
        w_reg_src   = 2'd0;
        w_alu_src   = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_ifetch    = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_sel    = 2'd0;

        // ALU operand/op selection stays stable from EXEC through WB.
        if ((r_state == StExec) || (r_state == StMem) || (r_state == StWb)) begin
            case (w_opc_q)
                OpcI, OpcLd, OpcJalr: w_alu_src = 1'b1;
                OpcSt, OpcLui: begin
                    w_alu_op  = 2'd1;
                    w_alu_src = 1'b1;
                end
                OpcBr:   w_alu_op = 2'd2;
                default: ;
            endcase
        end

        case (r_state)
            StFetch: begin
                w_ifetch   = 1'b1;
                w_mem_read = 1'b1;
                w_ir_write = w_ready;
            end
            StDecode: begin
                w_pc_write = (w_opc_live == OpcFence);
            end
            StExec: begin
                if (w_opc_q == OpcBr) begin
                    w_branch   = 1'b1;
                    w_pc_write = 1'b1;
                    w_pc_sel   = io_ctrl.branch_taken ? 2'd1 : 2'd0;
                end
            end
            StMem: begin
                if (w_opc_q == OpcSt) begin
                    w_mem_write = 1'b1;
                    w_pc_write  = w_ready;
                end else begin
                    w_mem_read = 1'b1;
                end
            end
            StWb: begin
                w_reg_write = 1'b1;
                w_pc_write  = 1'b1;
                case (w_opc_q)
                    OpcLd:    w_reg_src = 2'd1;
                    OpcAuipc: w_reg_src = 2'd2;
                    OpcJal: begin
                        w_reg_src = 2'd3;
                        w_pc_sel  = 2'd1;
                    end
                    OpcJalr: begin
                        w_reg_src = 2'd3;
                        w_pc_sel  = 2'd2;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Everything is forced low while rst is held.
    assign io_ctrl.ALUOp    = rst ? 2'd0 : w_alu_op;
    assign io_ctrl.RegSrc   = rst ? 2'd0 : w_reg_src;
    assign io_ctrl.ALUSrc   = !rst && w_alu_src;
    assign io_ctrl.RegWrite = !rst && w_reg_write;
    assign io_ctrl.MemRead  = !rst && w_mem_read;
    assign io_ctrl.MemWrite = !rst && w_mem_write;
    assign io_ctrl.Branch   = !rst && w_branch;
    assign io_ctrl.IFetch   = !rst && w_ifetch;
    assign io_ctrl.IRWrite  = !rst && w_ir_write;
    assign io_ctrl.PCWrite  = !rst && w_pc_write;
    assign io_ctrl.PCSel    = rst ? 2'd0 : w_pc_sel;
    assign io_ctrl.trap     = !rst && (r_state == StTrap);
    assign io_ctrl.cause    = rst ? 2'd0 : r_cause;

`ifdef CTRL_INSTRET_EN
    logic [CNT_W-1:0] r_instret;

    // Retired-instruction counter: one count per PC update, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (w_pc_write) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign io_ctrl.instret = rst ? '0 : r_instret;
`else
    assign io_ctrl.instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (WAIT_LIMIT=4). Each cycle pushes the expected
// control vector to a scoreboard queue and pops/compares it mid-cycle at the negedge.
module tb_multicycle_control;

    localparam int unsigned CNT_W = 32;

    typedef struct {
        string       tag;
        logic [16:0] ctl;
        logic [31:0] instret;
    } exp_t;

    logic        clk;
    logic        rst;
    exp_t        sb[$];
    int          checks;
    int          errors;
    logic [31:0] model_instret;
    logic [16:0] w_obs;

    logic [16:0] c_idle;
    logic [16:0] c_f_ok;
    logic [16:0] c_f_wait;
    logic [16:0] c_mem_ld;
    logic [16:0] c_trap1;
    logic [16:0] c_trap2;

    multicycle_control_if #(.CNT_W(CNT_W)) u_if ();

    multicycle_control #(
        .CNT_W     (CNT_W),
        .WAIT_LIMIT(4)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_ctrl(u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign w_obs = {u_if.ALUOp, u_if.RegSrc, u_if.ALUSrc, u_if.RegWrite, u_if.MemRead,
                    u_if.MemWrite, u_if.Branch, u_if.IFetch, u_if.IRWrite, u_if.PCWrite,
                    u_if.PCSel, u_if.trap, u_if.cause};

    function automatic logic [16:0] ctl(input logic [1:0] aluop, input logic [1:0] regsrc,
                                        input logic alusrc, input logic regw, input logic mr,
                                        input logic mw, input logic br, input logic ifetch,
                                        input logic irw, input logic pcw,
                                        input logic [1:0] pcsel, input logic tr,
                                        input logic [1:0] cause);
        return {aluop, regsrc, alusrc, regw, mr, mw, br, ifetch, irw, pcw, pcsel, tr, cause};
    endfunction

    function automatic logic [16:0] alu(input logic [1:0] aluop, input logic alusrc);
        return ctl(aluop, 2'd0, alusrc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0,
                   2'd0);
    endfunction

    function automatic logic [16:0] wb(input logic [1:0] aluop, input logic alusrc,
                                       input logic [1:0] regsrc, input logic [1:0] pcsel);
        return ctl(aluop, regsrc, alusrc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, pcsel,
                   1'b0, 2'd0);
    endfunction

    // One clock: drive inputs, queue expectation, compare at negedge, advance past posedge.
    task automatic cyc(input string tag, input logic [16:0] c, input logic mr, input logic bt);
        exp_t e;
        exp_t g;
        u_if.mem_ready    = mr;
        u_if.branch_taken = bt;
        e.tag = tag;
        e.ctl = c;
`ifdef CTRL_INSTRET_EN
        e.instret = rst ? 32'd0 : model_instret;
`else
        e.instret = 32'd0;
`endif
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        checks++;
        assert (w_obs === g.ctl) else begin
            errors++;
            $error("FAIL %s ctl got %h want %h", g.tag, w_obs, g.ctl);
        end
        checks++;
        assert (u_if.instret === g.instret) else begin
            errors++;
            $error("FAIL %s instret got %0d want %0d", g.tag, u_if.instret, g.instret);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_instret = 32'd0;
        end else if (c[5]) begin
            model_instret = model_instret + 32'd1;
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        model_instret = 32'd0;
        rst           = 1'b1;
        u_if.opcode       = 7'd0;
        u_if.mem_ready    = 1'b0;
        u_if.branch_taken = 1'b0;

        c_idle   = 17'd0;
        c_f_ok   = ctl(2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0,
                       2'd0);
        c_f_wait = ctl(2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0,
                       2'd0);
        c_mem_ld = ctl(2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0,
                       2'd0);
        c_trap1  = ctl(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1,
                       2'd1);
        c_trap2  = ctl(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1,
                       2'd2);

        // Reset: all outputs low.
        cyc("reset", c_idle, 1'b1, 1'b1);
        rst = 1'b0;

        // ADD, zero wait.
        u_if.opcode = 7'b0110011;
        cyc("add_fetch", c_f_ok, 1'b1, 1'b0);
        cyc("add_decode", c_idle, 1'b0, 1'b0);
        cyc("add_exec", alu(2'd0, 1'b0), 1'b0, 1'b0);
        cyc("add_wb", wb(2'd0, 1'b0, 2'd0, 2'd0), 1'b0, 1'b0);

        // LW with two wait cycles in MEM.
        u_if.opcode = 7'b0000011;
        cyc("lw_fetch", c_f_ok, 1'b1, 1'b0);
        cyc("lw_decode", c_idle, 1'b1, 1'b0);
        cyc("lw_exec", alu(2'd0, 1'b1), 1'b0, 1'b0);
        cyc("lw_mem0", c_mem_ld, 1'b0, 1'b0);
        cyc("lw_mem1", c_mem_ld, 1'b0, 1'b0);
        cyc("lw_mem2", c_mem_ld, 1'b1, 1'b0);
        cyc("lw_wb", wb(2'd0, 1'b1, 2'd1, 2'd0), 1'b0, 1'b0);

        // BEQ taken, then not taken.
        u_if.opcode = 7'b1100011;
        cyc("beq1_fetch", c_f_ok, 1'b1, 1'b0);
        cyc("beq1_decode", c_idle, 1'b0, 1'b1);
        cyc("beq1_exec", ctl(2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1,
                             1'b0, 2'd0), 1'b0, 1'b1);
        cyc("beq0_fetch", c_f_ok, 1'b1, 1'b1);
        cyc("beq0_decode", c_idle, 1'b1, 1'b0);
        cyc("beq0_exec", ctl(2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0,
                             1'b0, 2'd0), 1'b1, 1'b0);

        // JALR then JAL.
        u_if.opcode = 7'b1100111;
        cyc("jalr_fetch", c_f_ok, 1'b1, 1'b0);
        cyc("jalr_decode", c_idle, 1'b0, 1'b0);
        cyc("jalr_exec", alu(2'd0, 1'b1), 1'b0, 1'b0);
        cyc("jalr_wb", wb(2'd0, 1'b1, 2'd3, 2'd2), 1'b0, 1'b0);
        u_if.opcode = 7'b1101111;
        cyc("jal_fetch", c_f_ok, 1'b1, 1'b0);
        cyc("jal_decode", c_idle, 1'b0, 1'b0);
        cyc("jal_exec", alu(2'd0, 1'b0), 1'b0, 1'b0);
        cyc("jal_wb", wb(2'd0, 1'b0, 2'd3, 2'd1), 1'b0, 1'b0);

        // SW, zero wait: PC updates in the completing MEM cycle.
        u_if.opcode = 7'b0100011;
        cyc("sw_fetch", c_f_ok, 1'b1, 1'b0);
        cyc("sw_decode", c_idle, 1'b0, 1'b0);
        cyc("sw_exec", alu(2'd1, 1'b1), 1'b0, 1'b0);
        cyc("sw_mem", ctl(2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0,
                          1'b0, 2'd0), 1'b1, 1'b0);

        // FENCE retires in DECODE.
        u_if.opcode = 7'b0001111;
        cyc("fence_fetch", c_f_ok, 1'b1, 1'b0);
        cyc("fence_decode", ctl(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                2'd0, 1'b0, 2'd0), 1'b0, 1'b0);

        // LUI and AUIPC.
        u_if.opcode = 7'b0110111;
        cyc("lui_fetch", c_f_ok, 1'b1, 1'b0);
        cyc("lui_decode", c_idle, 1'b0, 1'b0);
        cyc("lui_exec", alu(2'd1, 1'b1), 1'b0, 1'b0);
        cyc("lui_wb", wb(2'd1, 1'b1, 2'd0, 2'd0), 1'b0, 1'b0);
        u_if.opcode = 7'b0010111;
        cyc("auipc_fetch", c_f_ok, 1'b1, 1'b0);
        cyc("auipc_decode", c_idle, 1'b0, 1'b0);
        cyc("auipc_exec", alu(2'd0, 1'b0), 1'b0, 1'b0);
        cyc("auipc_wb", wb(2'd0, 1'b0, 2'd2, 2'd0), 1'b0, 1'b0);

        // LW with 3 waits in FETCH and 3 in MEM: counter restarts on MEM entry.
        u_if.opcode = 7'b0000011;
        for (int i = 0; i < 3; i++) cyc("lw2_fwait", c_f_wait, 1'b0, 1'b0);
        cyc("lw2_fetch", c_f_ok, 1'b1, 1'b0);
        cyc("lw2_decode", c_idle, 1'b0, 1'b0);
        cyc("lw2_exec", alu(2'd0, 1'b1), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("lw2_mwait", c_mem_ld, 1'b0, 1'b0);
        cyc("lw2_mem", c_mem_ld, 1'b1, 1'b0);
        cyc("lw2_wb", wb(2'd0, 1'b1, 2'd1, 2'd0), 1'b0, 1'b0);

        // mem_ready on the 4th wait cycle completes normally (ADDI).
        u_if.opcode = 7'b0010011;
        for (int i = 0; i < 3; i++) cyc("addi_fwait", c_f_wait, 1'b0, 1'b0);
        cyc("addi_fetch4", c_f_ok, 1'b1, 1'b0);
        cyc("addi_decode", c_idle, 1'b0, 1'b0);
        cyc("addi_exec", alu(2'd0, 1'b1), 1'b0, 1'b0);
        cyc("addi_wb", wb(2'd0, 1'b1, 2'd0, 2'd0), 1'b0, 1'b0);

        // Reset in EXEC aborts the ADD: no PC update, counter cleared.
        u_if.opcode = 7'b0110011;
        cyc("abort_fetch", c_f_ok, 1'b1, 1'b0);
        cyc("abort_decode", c_idle, 1'b0, 1'b0);
        rst = 1'b1;
        cyc("abort_rst", c_idle, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("post_fetch", c_f_ok, 1'b1, 1'b0);
        cyc("post_decode", c_idle, 1'b0, 1'b0);
        cyc("post_exec", alu(2'd0, 1'b0), 1'b0, 1'b0);
        cyc("post_wb", wb(2'd0, 1'b0, 2'd0, 2'd0), 1'b0, 1'b0);

        // Illegal opcode traps after DECODE and stays there.
        u_if.opcode = 7'b1111111;
        cyc("ill_fetch", c_f_ok, 1'b1, 1'b0);
        cyc("ill_decode", c_idle, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cyc("ill_trap", c_trap1, 1'b1, 1'b1);
        rst = 1'b1;
        cyc("ill_rst", c_idle, 1'b1, 1'b0);
        rst = 1'b0;

        // Bus timeout in FETCH; at the limit mem_ready=1 no longer completes.
        u_if.opcode = 7'b0110011;
        for (int i = 0; i < 4; i++) cyc("to_fwait", c_f_wait, 1'b0, 1'b0);
        cyc("to_limit", c_f_wait, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("to_trap", c_trap2, 1'b1, 1'b0);
        rst = 1'b1;
        cyc("to_rst", c_idle, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("to_recover", c_f_ok, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV32I core: replaces the single-cycle opcode decoder with a registered FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB, stalling on a shared memory handshake. It drives the same datapath control signals (ALUOp, RegSrc, ALUSrc, RegWrite, MemRead, MemWrite, Branch). It adds PC-write sequencing, PC source selection with correct JALR link/target handling, illegal-opcode and bus-timeout traps, and a retired-instruction counter.

## Interface
- CNT_W, 32: width of retired-instruction counter.
- WAIT_LIMIT, 0: consecutive wait cycles before a bus-timeout trap; 0 disables the timeout.
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- opcode  in  7  instruction[6:0] from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- branch_taken  in  1  branch comparator result; sampled in EXEC for B-type.
- ALUOp  out  2  0 decode funct, 1 ADD, 2 SUB.
- RegSrc  out  2  0 ALU, 1 memory, 2 PC+imm, 3 PC+4.
- ALUSrc  out  1  0 rs2, 1 immediate.
- RegWrite, MemRead, MemWrite, Branch  out  1 each  datapath enables.
- IFetch  out  1  memory address mux selects PC (instruction fetch).
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  update PC this cycle.
- PCSel  out  2  0 PC+4, 1 PC+imm, 2 {ALU[31:1],1'b0}.
- trap  out  1  sticky; core halted.
- cause  out  2  0 none, 1 illegal opcode, 2 bus timeout.
- instret  out  CNT_W  retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are Moore-decoded from the state and the latched opcode op_q; all outputs not listed below are 0.
- FETCH: IFetch=1, MemRead=1. If mem_ready=1: IRWrite=1 and next state DECODE; otherwise hold.
- DECODE: latch opcode into op_q.
  - Unknown opcode -> TRAP, cause=1.
  - FENCE: PCWrite=1, PCSel=0 -> FETCH.
  - All other opcodes -> EXEC.
- EXEC: ALUOp/ALUSrc per op_q. R: 0/0. I, LD, JALR: 0/1. S, LUI: 1/1. B: 2/0. AUIPC, JAL: 0/0.
  - B: Branch=1, PCWrite=1, PCSel = branch_taken ? 1 : 0 -> FETCH.
  - LD, S -> MEM.
  - Others -> WB.
- MEM: ALU inputs held as in EXEC. LD: MemRead=1; S: MemWrite=1. Hold until mem_ready.
  - S then goes to FETCH with PCWrite=1, PCSel=0.
  - LD then goes to WB.
- WB: RegWrite=1, PCWrite=1, ALU inputs held. RegSrc: LD 1, AUIPC 2, JAL/JALR 3, otherwise 0. PCSel: JAL 1, JALR 2, otherwise 0. Next state FETCH.
- TRAP: all enables 0, trap=1, cause held. Only rst exits TRAP.
- Wait counter: cleared on entry to FETCH or MEM; increments each cycle in those states with mem_ready=0. When WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT, next state TRAP with cause=2.
- instret increments by 1 on every cycle with PCWrite=1 and wraps modulo 2^CNT_W.

## Timing
- While rst=1: state <= FETCH; op_q, wait counter, instret, trap, cause <= 0; all outputs forced 0. The first cycle after rst deasserts is FETCH with MemRead=1.
- CPI with zero wait (mem_ready=1 on the first cycle of each access): FENCE 2, branch 3, ALU/LUI/AUIPC/JAL/JALR 4, store 4, load 5. Each wait cycle adds one cycle.
- mem_ready is ignored outside FETCH and MEM.
- A timeout takes priority over a same-cycle mem_ready=1 only when the counter has already reached the limit. A mem_ready=1 on the limit-reaching cycle completes normally.
- rst mid-instruction aborts it: no PCWrite and no instret increment.

## Configuration
- CTRL_INSTRET_EN defined: instret counter implemented as above.
- CTRL_INSTRET_EN undefined: no counter register; instret tied to 0. FSM behaviour is otherwise identical.

## Test plan
- ADD (0110011), mem_ready=1 -> states F,D,E,WB. RegWrite=1 only in WB; PCWrite once; instret 0->1 after 4 cycles.
- LW (0000011) with 2 wait cycles in MEM -> MemRead held 3 MEM cycles; WB RegSrc=1; total 7 cycles.
- BEQ (1100011), branch_taken=1 then a second BEQ with branch_taken=0 -> EXEC Branch=1, ALUOp=2, PCSel=1 then 0; 3 cycles each.
- JALR (1100111) -> EXEC ALUSrc=1; WB RegSrc=3, PCSel=2; JAL (1101111) -> WB PCSel=1.
- opcode 7'b1111111 -> TRAP after DECODE, cause=1, all enables 0 for 10 cycles; rst -> FETCH, trap=0.
- WAIT_LIMIT=4, mem_ready=0 in FETCH -> TRAP, cause=2 after 4 wait cycles; repeat with mem_ready=1 on the 4th wait cycle -> no trap.
